// File: rtl/lcd_bus_responder.sv
// Receive side of the character-LCD bus: decodes HD44780-style instructions
// and data writes into a 2x16 buffer, and answers status/data reads.
module lcd_bus_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_db,
  output logic [7:0] db_out,
  output logic       db_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       display_on,
  output logic       busy,
  output logic       wr_strobe,
  output logic       err_busy_wr
);

  localparam int MAXC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] BUSY_LD  = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t          r_state, w_state_nx;
  logic            r_e_s1, r_e_s2, r_rs_s1, r_rs_s2, r_rw_s1, r_rw_s2;
  logic [7:0]      r_db_s1, r_db_s2;
  logic            r_cap_rs, r_cap_rw;
  logic [7:0]      r_cap_db;
  logic            r_pend;
  logic [6:0]      r_ac, w_ac_nx;
  logic            r_id, w_id_nx;
  logic            r_cg, w_cg_nx;
  logic            r_disp, w_disp_nx;
  logic            r_busy;
  logic [CW-1:0]   r_busy_cnt;
  logic            w_busy_ld;
  logic [CW-1:0]   w_busy_val;
  logic [4:0]      r_clr_idx, w_clr_idx_nx;
  logic            w_we;
  logic [4:0]      w_widx;
  logic [7:0]      w_wdata;
  logic            r_wr_strobe, w_wr_strobe_nx;
  logic            r_err, w_err_nx;
  logic [7:0]      r_db_out, w_db_out_nx;
  logic            r_db_oe;
  logic [7:0]      r_rd_char;
  logic [7:0]      r_buf [32];
  logic            w_e_fall;
  logic            w_rd_act;

  function automatic logic [4:0] buf_idx(input logic [6:0] ac);
    return {ac[6], ac[3:0]};
  endfunction

  // Move the address counter one step, wrapping between the two line windows.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nx;
    if (inc) begin
      if (ac == 7'h0F)      nx = 7'h40;
      else if (ac == 7'h4F) nx = 7'h00;
      else                  nx = ac + 7'd1;
    end else begin
      if (ac == 7'h00)      nx = 7'h4F;
      else if (ac == 7'h40) nx = 7'h0F;
      else                  nx = ac - 7'd1;
    end
    return nx;
  endfunction

  // Falling edge seen between the two synchronizer stages.
  assign w_e_fall = r_e_s2 & ~r_e_s1;
  assign w_rd_act = r_e_s1 & r_rw_s1;

  // Bus synchronizers and capture of the transfer fields while E is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e_s1   <= 1'b0;
      r_e_s2   <= 1'b0;
      r_rs_s1  <= 1'b0;
      r_rs_s2  <= 1'b0;
      r_rw_s1  <= 1'b0;
      r_rw_s2  <= 1'b0;
      r_db_s1  <= 8'h00;
      r_db_s2  <= 8'h00;
      r_cap_rs <= 1'b0;
      r_cap_rw <= 1'b0;
      r_cap_db <= 8'h00;
    end else begin
      r_e_s1  <= lcd_e;
      r_e_s2  <= r_e_s1;
      r_rs_s1 <= lcd_rs;
      r_rs_s2 <= r_rs_s1;
      r_rw_s1 <= lcd_rw;
      r_rw_s2 <= r_rw_s1;
      r_db_s1 <= lcd_db;
      r_db_s2 <= r_db_s1;
      if (r_e_s2) begin
        r_cap_rs <= r_rs_s2;
        r_cap_rw <= r_rw_s2;
        r_cap_db <= r_db_s2;
      end
    end
  end

  // Next-state, register updates and buffer write port.
  always_comb begin
    w_state_nx     = r_state;
    w_ac_nx        = r_ac;
    w_id_nx        = r_id;
    w_cg_nx        = r_cg;
    w_disp_nx      = r_disp;
    w_clr_idx_nx   = r_clr_idx;
    w_busy_ld      = 1'b0;
    w_busy_val     = BUSY_LD;
    w_we           = 1'b0;
    w_widx         = buf_idx(r_ac);
    w_wdata        = r_cap_db;
    w_wr_strobe_nx = 1'b0;
    w_err_nx       = 1'b0;
    if (!w_rd_act)     w_db_out_nx = 8'h00;
    else if (!r_rs_s1) w_db_out_nx = {r_busy, r_ac};
    else if (r_busy)   w_db_out_nx = 8'h00;
    else               w_db_out_nx = r_buf[buf_idx(r_ac)];

    case (r_state)
      ST_IDLE: begin
        if (w_e_fall || r_pend) w_state_nx = ST_EXEC;
        else                    w_state_nx = ST_IDLE;
      end
      ST_EXEC: begin
        w_state_nx = ST_IDLE;
        if (r_cap_rw) begin
          if (r_cap_rs && !r_busy) w_ac_nx = ac_step(r_ac, r_id);
          else                     w_ac_nx = r_ac;
        end else if (r_busy) begin
          w_err_nx = 1'b1;
        end else if (r_cap_rs) begin
          w_busy_ld = 1'b1;
          if (!r_cg) begin
            w_we           = 1'b1;
            w_wr_strobe_nx = 1'b1;
            w_ac_nx        = ac_step(r_ac, r_id);
          end else begin
            w_ac_nx = r_ac;
          end
        end else begin
          // Instruction: the most significant set bit selects the command.
          w_busy_ld = (r_cap_db != 8'h00);
          if (r_cap_db[7]) begin
            w_ac_nx = {r_cap_db[6], 2'b00, r_cap_db[3:0]};
            w_cg_nx = 1'b0;
          end else if (r_cap_db[6]) begin
            w_cg_nx = 1'b1;
          end else if (r_cap_db[5]) begin
            w_cg_nx = r_cg;
          end else if (r_cap_db[4]) begin
            if (!r_cap_db[3]) w_ac_nx = ac_step(r_ac, r_cap_db[2]);
            else              w_ac_nx = r_ac;
          end else if (r_cap_db[3]) begin
            w_disp_nx = r_cap_db[2];
          end else if (r_cap_db[2]) begin
            w_id_nx = r_cap_db[1];
          end else if (r_cap_db[1]) begin
            w_ac_nx    = 7'h00;
            w_busy_val = CLEAR_LD;
          end else if (r_cap_db[0]) begin
            w_state_nx   = ST_CLEAR;
            w_clr_idx_nx = 5'd0;
            w_busy_val   = CLEAR_LD;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end
      end
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_widx  = r_clr_idx;
        w_wdata = 8'h20;
        if (r_clr_idx == 5'd31) begin
          w_state_nx   = ST_IDLE;
          w_clr_idx_nx = 5'd0;
          w_ac_nx      = 7'h00;
          w_id_nx      = 1'b1;
        end else begin
          w_state_nx   = ST_CLEAR;
          w_clr_idx_nx = r_clr_idx + 5'd1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Control state, busy timer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_pend      <= 1'b0;
      r_ac        <= 7'h00;
      r_id        <= 1'b1;
      r_cg        <= 1'b0;
      r_disp      <= 1'b0;
      r_clr_idx   <= 5'd0;
      r_busy      <= 1'b0;
      r_busy_cnt  <= '0;
      r_wr_strobe <= 1'b0;
      r_err       <= 1'b0;
      r_db_out    <= 8'h00;
      r_db_oe     <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      // A fall during the clear sweep is held until the FSM is idle again.
      r_pend      <= (r_pend | w_e_fall) & (r_state != ST_IDLE);
      r_ac        <= w_ac_nx;
      r_id        <= w_id_nx;
      r_cg        <= w_cg_nx;
      r_disp      <= w_disp_nx;
      r_clr_idx   <= w_clr_idx_nx;
      r_wr_strobe <= w_wr_strobe_nx;
      r_err       <= w_err_nx;
      r_db_out    <= w_db_out_nx;
      r_db_oe     <= w_rd_act;
      if (w_busy_ld) begin
        r_busy_cnt <= w_busy_val;
        r_busy     <= 1'b1;
      end else if (r_busy_cnt != '0) begin
        r_busy_cnt <= r_busy_cnt - CW'(1);
        r_busy     <= (r_busy_cnt != CW'(1));
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  // Character buffer and display-side read port (old data on collision).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
      r_rd_char <= 8'h20;
    end else begin
      if (w_we) r_buf[w_widx] <= w_wdata;
      r_rd_char <= r_buf[rd_addr];
    end
  end

  assign db_out      = r_db_out;
  assign db_oe       = r_db_oe;
  assign rd_char     = r_rd_char;
  assign display_on  = r_disp;
  assign busy        = r_busy;
  assign wr_strobe   = r_wr_strobe;
  assign err_busy_wr = r_err;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder with shortened busy durations.
module tb_lcd_bus_responder;

  localparam int BUSY_N  = 40;
  localparam int CLEAR_N = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_db;
  logic [7:0] db_out;
  logic       db_oe;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic       display_on, busy, wr_strobe, err_busy_wr;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;
  int wr_cnt  = 0;

  lcd_bus_responder #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
    .clk(clk), .reset(reset), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_db(lcd_db), .db_out(db_out), .db_oe(db_oe), .rd_addr(rd_addr),
    .rd_char(rd_char), .display_on(display_on), .busy(busy),
    .wr_strobe(wr_strobe), .err_busy_wr(err_busy_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (err_busy_wr) err_cnt <= err_cnt + 1;
    if (wr_strobe)   wr_cnt  <= wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b0; lcd_db = d;
    ticks(2);
    lcd_e = 1'b1;
    ticks(4);
    lcd_e = 1'b0;
    ticks(4);
  endtask

  task automatic status_read(output logic [7:0] v, output logic oe);
    lcd_rs = 1'b0; lcd_rw = 1'b1;
    ticks(2);
    lcd_e = 1'b1;
    ticks(4);
    v  = db_out;
    oe = db_oe;
    lcd_e = 1'b0;
    ticks(4);
  endtask

  task automatic rd_check(input logic [4:0] a, input logic [7:0] exp, input string tag);
    rd_addr = a;
    ticks(1);
    chk($sformatf("%s[%0d]", tag, a), rd_char, exp);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_display_on"}, {7'd0, display_on}, 8'h00);
    chk({tag, "_busy"},       {7'd0, busy},       8'h00);
    chk({tag, "_db_oe"},      {7'd0, db_oe},      8'h00);
    chk({tag, "_db_out"},     db_out,             8'h00);
    chk({tag, "_wr_strobe"},  {7'd0, wr_strobe},  8'h00);
    chk({tag, "_err"},        {7'd0, err_busy_wr}, 8'h00);
    chk({tag, "_rd_char"},    rd_char,            8'h20);
  endtask

  initial begin
    logic [7:0] sv;
    logic       soe;
    reset = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
    lcd_db = 8'h00; rd_addr = 5'd0;
    ticks(3);
    reset_outputs("rst");
    reset = 1'b1;
    ticks(2);

    for (int i = 0; i < 32; i++) rd_check(5'(i), 8'h20, "init");
    status_read(sv, soe);
    chk("init_status", sv, 8'h00);
    chk("init_status_oe", {7'd0, soe}, 8'h01);
    chk("oe_drop", {7'd0, db_oe}, 8'h00);

    // Clear, then two characters at the start of line 1.
    bus_write(1'b0, 8'h01); ticks(CLEAR_N + 5);
    bus_write(1'b1, 8'h50); ticks(BUSY_N + 5);
    bus_write(1'b1, 8'h31); ticks(BUSY_N + 5);
    rd_check(5'd0, 8'h50, "P");
    rd_check(5'd1, 8'h31, "one");
    status_read(sv, soe);
    chk("ac_after_2", sv, 8'h02);
    chk("wr_cnt_2", 8'(wr_cnt), 8'h02);

    // Line 1 end wraps into line 2.
    bus_write(1'b0, 8'h8F); ticks(BUSY_N + 5);
    bus_write(1'b1, 8'h41); ticks(BUSY_N + 5);
    bus_write(1'b1, 8'h42); ticks(BUSY_N + 5);
    rd_check(5'd15, 8'h41, "wrap");
    rd_check(5'd16, 8'h42, "wrap");
    status_read(sv, soe);
    chk("ac_wrap", sv, 8'h41);

    // Decrement mode at the last cell, then shift-left wrap from 0x00.
    bus_write(1'b0, 8'hCF); ticks(BUSY_N + 5);
    bus_write(1'b0, 8'h04); ticks(BUSY_N + 5);
    bus_write(1'b1, 8'h58); ticks(BUSY_N + 5);
    rd_check(5'd31, 8'h58, "last");
    status_read(sv, soe);
    chk("ac_dec", sv, 8'h4E);
    bus_write(1'b0, 8'h80); ticks(BUSY_N + 5);
    bus_write(1'b0, 8'h10); ticks(BUSY_N + 5);
    status_read(sv, soe);
    chk("ac_shift_wrap", sv, 8'h4F);

    // Display on, then a status read and a data write inside the busy window.
    chk("err_cnt_0", 8'(err_cnt), 8'h00);
    bus_write(1'b0, 8'h0C);
    status_read(sv, soe);
    chk("status_busy", sv, 8'hCF);
    bus_write(1'b1, 8'h77);
    ticks(BUSY_N + 5);
    chk("display_on", {7'd0, display_on}, 8'h01);
    chk("err_cnt_1", 8'(err_cnt), 8'h01);
    chk("wr_cnt_5", 8'(wr_cnt), 8'h05);
    rd_check(5'd31, 8'h58, "kept");
    status_read(sv, soe);
    chk("ac_kept", sv, 8'h4F);

    // Reset in the middle of a clear sweep.
    bus_write(1'b0, 8'h01);
    ticks(9);
    reset = 1'b0;
    ticks(2);
    reset_outputs("midrst");
    reset = 1'b1;
    ticks(2);
    for (int i = 0; i < 32; i++) rd_check(5'(i), 8'h20, "post");
    status_read(sv, soe);
    chk("post_status", sv, 8'h00);
    bus_write(1'b1, 8'h33); ticks(BUSY_N + 5);
    status_read(sv, soe);
    chk("post_id_inc", sv, 8'h01);
    rd_check(5'd0, 8'h33, "post_wr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_bus_responder.md
# lcd_bus_responder

Receiving end of the character-LCD bus (E, RS, RW, DB[7:0]) driven by the score/status logic. It decodes HD44780-style instructions and data writes, and holds a 2x16 character buffer. The buffer can be read back by the VGA display path to mirror the score on screen, and it also serves as a cycle-accurate bus responder for simulation. It models the busy flag, the address counter and the read-back cycles. It never drives the physical LCD.

## Interface
- BUSY_CYCLES, 2000, busy duration after any accepted instruction or data write (40 us at 50 MHz).
- CLEAR_CYCLES, 82000, busy duration after Clear Display or Return Home.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- lcd_e  in  1  bus enable strobe.
- lcd_rs  in  1  0 = instruction/status, 1 = data.
- lcd_rw  in  1  0 = write, 1 = read.
- lcd_db  in  8  write data from the bus master.
- db_out  out  8  read data returned to the master.
- db_oe  out  1  high while a read cycle is active.
- rd_addr  in  5  display-side buffer index (0-15 = line 1, 16-31 = line 2).
- rd_char  out  8  character at rd_addr, registered.
- display_on  out  1  D bit from the last Display Control command.
- busy  out  1  internal busy flag.
- wr_strobe  out  1  one-cycle pulse per accepted DDRAM data write.
- err_busy_wr  out  1  one-cycle pulse when a write arrives while busy.

## Operation
- Synchronisation: lcd_e, lcd_rs, lcd_rw and lcd_db each pass through 2-FF synchronizers. While synced E is high, RS, RW and DB are captured every cycle. A transfer executes on the synced falling edge of E, using the last values captured while E was high.
- Address counter (AC, 7 bits): legal values are 0x00-0x0F and 0x40-0x4F. Buffer index = {AC[6], AC[3:0]}.
  - Increment wraps 0x0F->0x40 and 0x4F->0x00.
  - Decrement wraps 0x00->0x4F and 0x40->0x0F.
- Instruction writes (RS=0, RW=0), decoded by the most significant set bit:
  - 0x01 Clear: FSM enters CLEAR and writes 0x20 to all 32 entries, one per cycle. Then AC=0 and I/D=1. Busy for CLEAR_CYCLES.
  - 0x02/0x03 Home: AC=0. Busy for CLEAR_CYCLES.
  - 0000_01ab Entry mode: I/D=a. The S bit is ignored.
  - 0000_1dcb Display control: display_on=d.
  - 0001_sr00 Shift: if s=0, AC moves +1 (r=1) or -1 (r=0) with wrap. s=1 is ignored.
  - 001x_xxxx Function set: accepted, no effect.
  - 01xx_xxxx CGRAM address: sets cg_mode. Following data writes are discarded, with no AC change, until the next DDRAM-address command.
  - 1aaa_aaaa DDRAM address: AC = {a[6], 2'b00, a[3:0]}. Clears cg_mode.
  - 0x00: no-op, no busy.
- Data write (RS=1, RW=0): buffer[AC] <= DB, then AC advances per I/D. wr_strobe pulses on the same cycle as the buffer write.
- Status read (RS=0, RW=1): db_out = {busy, AC} while synced E is high, and db_oe=1. Allowed while busy.
- Data read (RS=1, RW=1): db_out = buffer[AC] while E is high. AC advances per I/D on the E fall. Allowed only when not busy; when busy, db_out is 0x00 and AC is unchanged.
- Any write while busy=1: ignored, and err_busy_wr pulses.
- Busy counter: every accepted write except 0x00 loads the counter with its duration and sets busy. The counter decrements each cycle; busy clears on the cycle it reaches 0.
- FSM states:
  - IDLE -> EXEC on a synced E fall.
  - EXEC -> CLEAR for command 0x01, otherwise back to IDLE.
  - CLEAR returns to IDLE after index 31.
- The display-side port is independent of bus activity. On a same-cycle write and read of the same index, rd_char returns the old value.

## Timing
- Reset values (asynchronous):
  - All buffer entries 0x20.
  - AC=0, I/D=1, cg_mode=0.
  - display_on=0, busy=0, db_oe=0, db_out=0x00.
  - wr_strobe=0, err_busy_wr=0, rd_char=0x20.
- Latency from raw lcd_e falling to buffer/AC update: 3 clk, i.e. 2 sync cycles plus 1 execute cycle.
- Latency from raw lcd_e rising to db_oe/db_out valid: 2 clk. Both drop 2 clk after the raw fall.
- E must stay high and low for at least 3 clk each; shorter pulses may be lost.
- Busy asserts on the execute cycle and lasts exactly N cycles.
- rd_char has 1-clk latency from rd_addr.
- Clear sweep: 32 cycles, which is well within CLEAR_CYCLES.
- Reset asserted mid-sweep or mid-busy returns everything to the reset values immediately. The sweep is not resumed.

## Test plan
- Reset, then read rd_addr 0..31 -> every entry is 0x20; status read returns 0x00; display_on=0.
- Write 0x01, wait out busy, write data 'P','1' -> rd_char[0]=0x50, rd_char[1]=0x31; status read returns 0x02.
- Write 0x8F then data 0x41 and 0x42 -> buffer[15]=0x41, buffer[16]=0x42 (wrap 0x0F->0x40).
- Write 0xCF, entry mode 0x04, data 0x58 -> buffer[31]=0x58, AC=0x4E. Then write 0x80, 0x10 -> AC=0x4F (decrement wrap 0x00->0x4F).
- Write 0x0C, then immediately a data write while busy -> display_on=1, err_busy_wr pulses once, buffer unchanged. Status read in the same window returns bit7=1.
- Write 0x01, deassert reset low 10 cycles into the sweep -> all outputs at reset values; buffer reads all 0x20.
